// File: rtl/mips32_run_pkg.sv
// ---------------------------------------------------------------------------
// mips32_run_pkg
// Shared types and constants for the mips32 run controller:
//   - run_state_t   : controller state (IDLE, RUN, DUMP, DONE)
//   - CAUSE_*       : halt_cause encodings reported by mips32_run_monitor
//   - trace_entry_w : width of one {pc, instr} trace FIFO entry
// ---------------------------------------------------------------------------
package mips32_run_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } run_state_t;

    localparam logic [2:0] CAUSE_NONE  = 3'd0;
    localparam logic [2:0] CAUSE_EXT   = 3'd1;
    localparam logic [2:0] CAUSE_HALTI = 3'd2;
    localparam logic [2:0] CAUSE_STUCK = 3'd3;
    localparam logic [2:0] CAUSE_MAX   = 3'd4;

    function automatic int trace_entry_w(input int addr_w, input int instr_w);
        return addr_w + instr_w;
    endfunction

endpackage

// File: rtl/mips32_trace_fifo.sv
// ---------------------------------------------------------------------------
// mips32_trace_fifo
// Show-ahead FIFO holding retired {pc, instr} pairs.
// Ports:
//   clock, reset   : clock, asynchronous active-high reset
//   i_flush        : empties the FIFO and clears the overflow flag
//   i_push/i_data  : write request and entry
//   i_pop          : read request (ignored while empty)
//   o_data         : head entry, zero while empty
//   o_full/o_empty : occupancy flags
//   o_ovf_sticky   : set when a push was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module mips32_trace_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_ovf_sticky
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             r_ovf;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_pop;
    logic w_push;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !w_push) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    assign o_data       = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_ovf_sticky = r_ovf;

endmodule

// File: rtl/mips32_run_monitor.sv
// ---------------------------------------------------------------------------
// mips32_run_monitor
// Run controller for the mips32 core: starts a run, counts retired
// instructions, detects a halt (external request, halt instruction word,
// stuck PC, cycle limit), then performs a dump-request handshake.
// Optional trace FIFO of retired {pc, instr} pairs, built only when the
// macro MIPS32_RUN_TRACE_EN is defined; otherwise the trace outputs are 0.
// Ports:
//   clock, reset          : clock, asynchronous active-high reset
//   start                 : pulse, starts a run from IDLE or DONE
//   retire/pc_in/instr_in : retiring instruction from the core
//   halt_req              : external halt level, sampled in RUN
//   dump_req/dump_ack     : dump handshake
//   running/done/halted   : run status (done is a one-cycle pulse)
//   halt_cause            : 0 none, 1 EXT, 2 HALTI, 3 STUCK, 4 MAX
//   cycle_count           : retired-instruction count of current/last run
//   trace_rd/trace_valid/trace_data/trace_ovf : trace FIFO readout
// ---------------------------------------------------------------------------
module mips32_run_monitor
    import mips32_run_pkg::*;
#(
    parameter int                 ADDR_W      = 32,
    parameter int                 INSTR_W     = 32,
    parameter int                 CYC_W       = 16,
    parameter int                 MAX_CYCLES  = 60,
    parameter int                 STALL_LIMIT = 4,
    parameter logic [INSTR_W-1:0] HALT_WORD   = 32'hFFFF_FFFF,
    parameter int                 TRACE_DEPTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      retire,
    input  logic [ADDR_W-1:0]         pc_in,
    input  logic [INSTR_W-1:0]        instr_in,
    input  logic                      halt_req,
    output logic                      dump_req,
    input  logic                      dump_ack,
    output logic                      running,
    output logic                      done,
    output logic                      halted,
    output logic [2:0]                halt_cause,
    output logic [CYC_W-1:0]          cycle_count,
    input  logic                      trace_rd,
    output logic                      trace_valid,
    output logic [ADDR_W+INSTR_W-1:0] trace_data,
    output logic                      trace_ovf
);

    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    run_state_t         r_state;
    run_state_t         w_state_nxt;
    logic [CYC_W-1:0]   r_cycle;
    logic [STALL_W-1:0] r_stall;
    logic [ADDR_W-1:0]  r_last_pc;
    logic               r_last_vld;
    logic [2:0]         r_cause;

    logic               w_run_start;
    logic               w_same_pc;
    logic               w_stuck;
    logic               w_max;
    logic [2:0]         w_cause;

    // Halt detection, priority EXT > HALTI > STUCK > MAX.
    // r_stall holds the number of consecutive retires seen at r_last_pc,
    // so the retire that makes it reach STALL_LIMIT declares the core stuck.
    assign w_same_pc = r_last_vld && (pc_in == r_last_pc);
    assign w_stuck   = retire && w_same_pc &&
                       (({1'b0, r_stall} + 1'b1) == (STALL_W+1)'(STALL_LIMIT));
    assign w_max     = retire &&
                       (({1'b0, r_cycle} + 1'b1) == (CYC_W+1)'(MAX_CYCLES));

    always_comb begin
        w_cause = CAUSE_NONE;
        if (halt_req) begin
            w_cause = CAUSE_EXT;
        end else if (retire && (instr_in == HALT_WORD)) begin
            w_cause = CAUSE_HALTI;
        end else if (w_stuck) begin
            w_cause = CAUSE_STUCK;
        end else if (w_max) begin
            w_cause = CAUSE_MAX;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_start = 1'b0;
        running     = 1'b0;
        halted      = 1'b0;
        dump_req    = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_run_start = 1'b1;
                end
            end
            RUN: begin
                running = 1'b1;
                if (w_cause != CAUSE_NONE) begin
                    w_state_nxt = DUMP;
                end
            end
            DUMP: begin
                dump_req = 1'b1;
                if (dump_ack) begin
                    done        = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                halted = 1'b1;
                if (start) begin
                    w_state_nxt = RUN;
                    w_run_start = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycle    <= '0;
            r_stall    <= '0;
            r_last_pc  <= '0;
            r_last_vld <= 1'b0;
            r_cause    <= CAUSE_NONE;
        end else if (w_run_start) begin
            r_cycle    <= '0;
            r_stall    <= '0;
            r_last_pc  <= '0;
            r_last_vld <= 1'b0;
            r_cause    <= CAUSE_NONE;
        end else if (r_state == RUN) begin
            if (retire) begin
                if (r_cycle != '1) begin
                    r_cycle <= r_cycle + 1'b1;
                end
                r_stall    <= w_same_pc ? r_stall + 1'b1 : STALL_W'(1);
                r_last_pc  <= pc_in;
                r_last_vld <= 1'b1;
            end
            if (w_cause != CAUSE_NONE) begin
                r_cause <= w_cause;
            end
        end
    end

    assign halt_cause  = r_cause;
    assign cycle_count = r_cycle;

`ifdef MIPS32_RUN_TRACE_EN
    localparam int TRACE_W = trace_entry_w(ADDR_W, INSTR_W);

    logic w_fifo_empty;
    logic w_fifo_full_unused;

    mips32_trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clock        (clock),
        .reset        (reset),
        .i_flush      (w_run_start),
        .i_push       ((r_state == RUN) && retire),
        .i_data       ({pc_in, instr_in}),
        .i_pop        (trace_rd),
        .o_data       (trace_data),
        .o_full       (w_fifo_full_unused),
        .o_empty      (w_fifo_empty),
        .o_ovf_sticky (trace_ovf)
    );

    assign trace_valid = !w_fifo_empty;
`else
    logic        w_unused_trace_rd;
    logic [31:0] w_unused_depth;

    assign w_unused_trace_rd = trace_rd;
    assign w_unused_depth    = 32'(TRACE_DEPTH);
    assign trace_valid       = 1'b0;
    assign trace_data        = '0;
    assign trace_ovf         = 1'b0;
`endif

endmodule

// File: tb/tb_mips32_run_monitor.sv
module tb_mips32_run_monitor;

    localparam int          CYC_W       = 16;
    localparam int          MAX_CYCLES  = 60;
    localparam int          STALL_LIMIT = 4;
    localparam int          DEPTH       = 8;
    localparam logic [31:0] HALTW       = 32'hFFFF_FFFF;
`ifdef MIPS32_RUN_TRACE_EN
    localparam bit TRACED = 1'b1;
`else
    localparam bit TRACED = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        retire = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] instr_in = '0;
    logic        halt_req = 1'b0;
    logic        dump_ack = 1'b0;
    logic        trace_rd = 1'b0;

    logic        dump_req, running, done, halted, trace_valid, trace_ovf;
    logic [2:0]  halt_cause;
    logic [15:0] cycle_count;
    logic [63:0] trace_data;

    always #5 clock = ~clock;

    mips32_run_monitor dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .retire      (retire),
        .pc_in       (pc_in),
        .instr_in    (instr_in),
        .halt_req    (halt_req),
        .dump_req    (dump_req),
        .dump_ack    (dump_ack),
        .running     (running),
        .done        (done),
        .halted      (halted),
        .halt_cause  (halt_cause),
        .cycle_count (cycle_count),
        .trace_rd    (trace_rd),
        .trace_valid (trace_valid),
        .trace_data  (trace_data),
        .trace_ovf   (trace_ovf)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: phase 0 idle, 1 run, 2 dump, 3 done.
    int          m_phase;
    int          m_cycles;
    int          m_cause;
    int          m_runlen;
    logic [31:0] m_lastpc;
    bit          m_have_last;
    logic [63:0] m_q[$];
    bit          m_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_cycles = 0; m_cause = 0; m_runlen = 0;
        m_lastpc = '0; m_have_last = 1'b0; m_q.delete(); m_ovf = 1'b0;
    endtask

    task automatic check_all();
        chk("running", running, m_phase == 1);
        chk("halted", halted, m_phase == 3);
        chk("dump_req", dump_req, m_phase == 2);
        chk("done", done, (m_phase == 2) && dump_ack);
        chk("halt_cause", halt_cause, m_cause);
        chk("cycle_count", cycle_count, m_cycles);
        if (TRACED) begin
            chk("trace_valid", trace_valid, m_q.size() != 0);
            chk("trace_data", trace_data, (m_q.size() != 0) ? m_q[0] : 64'h0);
            chk("trace_ovf", trace_ovf, m_ovf);
        end else begin
            chk("trace_valid", trace_valid, 0);
            chk("trace_data", trace_data, 0);
            chk("trace_ovf", trace_ovf, 0);
        end
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        int cause;
        if (TRACED && trace_rd && m_q.size() != 0) void'(m_q.pop_front());
        case (m_phase)
            0, 3: if (start) begin
                m_phase = 1; m_cycles = 0; m_cause = 0; m_runlen = 0;
                m_have_last = 1'b0; m_q.delete(); m_ovf = 1'b0;
            end
            1: begin
                cause = 0;
                if (halt_req) cause = 1;
                else if (retire && instr_in == HALTW) cause = 2;
                else if (retire && m_have_last && pc_in == m_lastpc &&
                         m_runlen + 1 == STALL_LIMIT) cause = 3;
                else if (retire && m_cycles + 1 == MAX_CYCLES) cause = 4;
                if (retire) begin
                    if (m_cycles < (1 << CYC_W) - 1) m_cycles++;
                    m_runlen = (m_have_last && pc_in == m_lastpc) ? m_runlen + 1 : 1;
                    m_lastpc = pc_in;
                    m_have_last = 1'b1;
                    if (TRACED) begin
                        if (m_q.size() < DEPTH) m_q.push_back({pc_in, instr_in});
                        else m_ovf = 1'b1;
                    end
                end
                if (cause != 0) begin
                    m_cause = cause;
                    m_phase = 2;
                end
            end
            2: if (dump_ack) m_phase = 3;
            default: ;
        endcase
    endtask

    task automatic step(input bit st, input bit rt, input logic [31:0] pc,
                        input logic [31:0] ins, input bit hr, input bit ack, input bit rd);
        @(negedge clock);
        start = st; retire = rt; pc_in = pc; instr_in = ins;
        halt_req = hr; dump_ack = ack; trace_rd = rd;
        #1;
        check_all();
        model_edge();
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] rin();
        return $urandom() & 32'h7FFF_FFFF;
    endfunction

    initial begin
        model_reset();
        repeat (2) @(negedge clock);
        #1;
        check_all();
        reset = 1'b0;

        // Cycle limit: 60 distinct PCs.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 60; i++) step(0, 1, i, rin(), 0, 0, 0);
        idle(1);
        chk("max_cause", halt_cause, 4);
        chk("max_dump_req", dump_req, 1);
        idle(2);
        step(0, 0, 0, 0, 0, 1, 0);
        idle(1);
        chk("max_halted", halted, 1);
        chk("max_count", cycle_count, 60);

        // Halt instruction on the 5th retire.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 32'h40 + 4 * i, rin(), 0, 0, 0);
        step(0, 1, 32'h50, HALTW, 0, 0, 0);
        idle(1);
        chk("halti_cause", halt_cause, 2);
        chk("halti_count", cycle_count, 5);
        step(0, 0, 0, 0, 0, 1, 0);

        // EXT beats HALTI and STUCK on the same retire.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h10, rin(), 0, 0, 0);
        step(0, 1, 32'h10, HALTW, 1, 0, 0);
        idle(1);
        chk("ext_cause", halt_cause, 1);
        step(0, 0, 0, 0, 0, 1, 0);

        // No halt on 0x10,0x10,0x14,0x10, then STUCK on four repeats.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 32'h10, rin(), 0, 0, 0);
        step(0, 1, 32'h10, rin(), 0, 0, 0);
        step(0, 1, 32'h14, rin(), 0, 0, 0);
        step(0, 1, 32'h10, rin(), 0, 0, 0);
        idle(1);
        chk("nostuck_running", running, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h10, rin(), 0, 0, 0);
        idle(1);
        chk("stuck_cause", halt_cause, 3);
        step(0, 0, 0, 0, 0, 1, 0);

        // Trace overflow, then drain in order.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 32'h200 + 4 * i, rin(), 0, 0, 0);
        idle(1);
        chk("ovf_after10", trace_ovf, TRACED);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);

        // Push and pop together while full: no overflow.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 32'h300 + 4 * i, rin(), 0, 0, 0);
        step(0, 1, 32'h400, rin(), 0, 0, 1);
        idle(1);
        chk("full_pushpop_ovf", trace_ovf, 0);
        chk("full_pushpop_valid", trace_valid, TRACED);
        step(0, 0, 0, 0, 1, 0, 0);

        // Reset while in DUMP, with dump_ack present: no done pulse.
        idle(1);
        @(negedge clock);
        dump_ack = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_dump_req", dump_req, 0);
        chk("rst_done", done, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cause", halt_cause, 0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        dump_ack = 1'b0;
        step(1, 0, 0, 0, 0, 0, 0);
        idle(1);
        chk("restart_count", cycle_count, 0);
        chk("restart_cause", halt_cause, 0);
        chk("restart_running", running, 1);

        // Randomised traffic against the model.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) < 7),
                 32'h100 + 4 * $urandom_range(0, 2),
                 ($urandom_range(0, 49) == 0) ? HALTW : rin(),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0));
        end
        idle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
